// File: rtl/id_pkg.sv
// Shared decode constants, the decoded-instruction record and immediate helpers for id_pipe.
package id_pkg;

  // Datapath fields are held at the widest supported XLEN and truncated at the outputs.
  localparam int unsigned XLEN_MAX = 64;

  localparam logic [6:0] TYPE_I   = 7'b0010011;
  localparam logic [6:0] TYPE_R_M = 7'b0110011;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] S        = 7'b0100011;
  localparam logic [6:0] L        = 7'b0000011;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] B        = 7'b1100011;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [4:0]  ZERO_REG = 5'd0;

  localparam logic READ_ENABLE   = 1'b1;
  localparam logic READ_DISABLE  = 1'b0;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  localparam logic [6:0] FUNCT7_M = 7'b0000001;

  typedef struct packed {
    logic [31:0]         inst;
    logic [XLEN_MAX-1:0] addr;
    logic [XLEN_MAX-1:0] op1;
    logic [XLEN_MAX-1:0] op2;
    logic                we;
    logic [4:0]          waddr;
    logic                long_op;
  } dec_inst_t;

  localparam dec_inst_t DEC_RESET = '{inst: NOP, default: '0};

  function automatic logic [XLEN_MAX-1:0] imm_i(input logic [11:0] imm12);
    return {{(XLEN_MAX-12){imm12[11]}}, imm12};
  endfunction

  function automatic logic [XLEN_MAX-1:0] imm_u(input logic [19:0] imm20);
    return {{(XLEN_MAX-32){imm20[19]}}, imm20, 12'b0};
  endfunction

endpackage

// File: rtl/id_scoreboard.sv
// Per-register pending-write bits for long-latency producers (loads, div/rem).
module id_scoreboard
  import id_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       set_en,
  input  logic [4:0] set_addr,
  input  logic       clr_en,
  input  logic [4:0] clr_addr,
  input  logic       flush_clr_en,
  input  logic [4:0] flush_clr_addr,
  input  logic [4:0] rs1_addr,
  input  logic [4:0] rs2_addr,
  input  logic [4:0] rd_addr,
  output logic       rs1_pending,
  output logic       rs2_pending,
  output logic       rd_pending
);

  logic [31:0] pending_q, pending_d;

  // A set of the same register in the same cycle overrides either clear.
  always_comb begin
    pending_d = pending_q;
    if (clr_en)       pending_d[clr_addr]       = 1'b0;
    if (flush_clr_en) pending_d[flush_clr_addr] = 1'b0;
    if (set_en)       pending_d[set_addr]       = 1'b1;
    pending_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  assign rs1_pending = pending_q[rs1_addr];
  assign rs2_pending = pending_q[rs2_addr];
  assign rd_pending  = pending_q[rd_addr];

endmodule

// File: rtl/id_pipe.sv
// Decode stage with ID/EXE register, operand forwarding and a pending-write scoreboard
// so long-latency producers stall only their true consumers.
module id_pipe
  import id_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_FWD = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [31:0]             inst_i,
  input  logic [XLEN-1:0]         inst_addr_i,
  output logic [4:0]              reg1_raddr_o,
  output logic [4:0]              reg2_raddr_o,
  input  logic [XLEN-1:0]         reg1_rdata_i,
  input  logic [XLEN-1:0]         reg2_rdata_i,
  input  logic [NUM_FWD-1:0]      fwd_we_i,
  input  logic [5*NUM_FWD-1:0]    fwd_waddr_i,
  input  logic [XLEN*NUM_FWD-1:0] fwd_wdata_i,
  input  logic                    lclr_valid_i,
  input  logic [4:0]              lclr_addr_i,
  input  logic                    flush_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [31:0]             out_inst_o,
  output logic [XLEN-1:0]         out_inst_addr_o,
  output logic [XLEN-1:0]         out_op1_o,
  output logic [XLEN-1:0]         out_op2_o,
  output logic                    out_reg_we_o,
  output logic [4:0]              out_reg_waddr_o,
  output logic                    out_long_o,
  output logic                    stall_o
);

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  assign opcode = inst_i[6:0];
  assign rd     = inst_i[11:7];
  assign rs1    = inst_i[19:15];
  assign rs2    = inst_i[24:20];

  logic rs1_re, rs2_re;

  always_comb begin
    rs1_re = READ_DISABLE;
    rs2_re = READ_DISABLE;
    case (opcode)
      TYPE_I, L, JALR: rs1_re = READ_ENABLE;
      TYPE_R_M, S, B: begin
        rs1_re = READ_ENABLE;
        rs2_re = READ_ENABLE;
      end
      default: ;
    endcase
  end

  assign reg1_raddr_o = rs1_re ? rs1 : ZERO_REG;
  assign reg2_raddr_o = rs2_re ? rs2 : ZERO_REG;

  logic [XLEN_MAX-1:0] rs1_val, rs2_val;

  // Walk from oldest to youngest so the lowest-index matching source wins.
  always_comb begin
    rs1_val = XLEN_MAX'(reg1_rdata_i);
    rs2_val = XLEN_MAX'(reg2_rdata_i);
    for (int i = int'(NUM_FWD) - 1; i >= 0; i--) begin
      if (fwd_we_i[i] && reg1_raddr_o != ZERO_REG && fwd_waddr_i[5*i +: 5] == reg1_raddr_o) begin
        rs1_val = XLEN_MAX'(fwd_wdata_i[XLEN*i +: XLEN]);
      end
      if (fwd_we_i[i] && reg2_raddr_o != ZERO_REG && fwd_waddr_i[5*i +: 5] == reg2_raddr_o) begin
        rs2_val = XLEN_MAX'(fwd_wdata_i[XLEN*i +: XLEN]);
      end
    end
  end

  dec_inst_t dec;

  always_comb begin
    dec      = '0;
    dec.inst = inst_i;
    dec.addr = XLEN_MAX'(inst_addr_i);
    dec.we   = WRITE_DISABLE;
    case (opcode)
      TYPE_I: begin
        dec.we  = WRITE_ENABLE;
        dec.op1 = rs1_val;
        dec.op2 = imm_i(inst_i[31:20]);
      end
      TYPE_R_M: begin
        dec.we      = WRITE_ENABLE;
        dec.op1     = rs1_val;
        dec.op2     = rs2_val;
        dec.long_op = (inst_i[31:25] == FUNCT7_M) && inst_i[14];
      end
      LUI: begin
        dec.we  = WRITE_ENABLE;
        dec.op1 = imm_u(inst_i[31:12]);
      end
      AUIPC: begin
        dec.we  = WRITE_ENABLE;
        dec.op1 = XLEN_MAX'(inst_addr_i);
        dec.op2 = imm_u(inst_i[31:12]);
      end
      S, B: begin
        dec.op1 = rs1_val;
        dec.op2 = rs2_val;
      end
      L: begin
        dec.we      = WRITE_ENABLE;
        dec.op1     = rs1_val;
        dec.long_op = 1'b1;
      end
      JAL: dec.we = WRITE_ENABLE;
      JALR: begin
        dec.we  = WRITE_ENABLE;
        dec.op1 = rs1_val;
      end
      default: dec.inst = NOP;
    endcase
    if (rd == ZERO_REG) dec.we = WRITE_DISABLE;
    dec.waddr = dec.we ? rd : ZERO_REG;
  end

  dec_inst_t out_q;
  logic      out_valid_q;
  logic      rs1_pending, rs2_pending, rd_pending;
  logic      rs1_hazard, rs2_hazard, waw_hazard, hazard, issue;

  // A source completing this cycle is picked up from the forwarding ports instead.
  assign rs1_hazard = rs1_pending && !(lclr_valid_i && lclr_addr_i == reg1_raddr_o);
  assign rs2_hazard = rs2_pending && !(lclr_valid_i && lclr_addr_i == reg2_raddr_o);
  assign waw_hazard = dec.long_op && rd_pending;
  assign hazard     = rs1_hazard || rs2_hazard || waw_hazard;

  assign in_ready_o = !rst_i && !flush_i && !hazard && (!out_valid_q || out_ready_i);
  assign issue      = in_valid_i && in_ready_o;
  assign stall_o    = in_valid_i && !rst_i && hazard;

  id_scoreboard u_sb (
    .clk            (clk_i),
    .rst            (rst_i),
    .set_en         (issue && dec.long_op),
    .set_addr       (rd),
    .clr_en         (lclr_valid_i),
    .clr_addr       (lclr_addr_i),
    .flush_clr_en   (flush_i && out_valid_q && out_q.long_op),
    .flush_clr_addr (out_q.waddr),
    .rs1_addr       (reg1_raddr_o),
    .rs2_addr       (reg2_raddr_o),
    .rd_addr        (rd),
    .rs1_pending    (rs1_pending),
    .rs2_pending    (rs2_pending),
    .rd_pending     (rd_pending)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_q       <= DEC_RESET;
    end else if (flush_i) begin
      out_valid_q <= 1'b0;
    end else if (issue) begin
      out_valid_q <= 1'b1;
      out_q       <= dec;
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid_o     = out_valid_q;
  assign out_inst_o      = out_q.inst;
  assign out_inst_addr_o = out_q.addr[XLEN-1:0];
  assign out_op1_o       = out_q.op1[XLEN-1:0];
  assign out_op2_o       = out_q.op2[XLEN-1:0];
  assign out_reg_we_o    = out_q.we;
  assign out_reg_waddr_o = out_q.waddr;
  assign out_long_o      = out_q.long_op;

  // Upper bits of the wide fields are dead when XLEN < XLEN_MAX.
  logic unused_out_bits;
  assign unused_out_bits = ^{out_q.addr, out_q.op1, out_q.op2};

endmodule

// File: tb/tb_id_pipe.sv
// Directed bench for id_pipe: expected records queue on accept and are checked on EXE handshake.
module tb_id_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, flush, lclr_valid, stall;
  logic [31:0] inst, inst_addr, r1d, r2d, out_inst, out_addr, out_op1, out_op2;
  logic [4:0]  r1a, r2a, lclr_addr, out_waddr;
  logic [1:0]  fwd_we;
  logic [9:0]  fwd_waddr;
  logic [63:0] fwd_wdata;
  logic        out_we, out_long;

  always #5 clk = ~clk;

  function automatic logic [31:0] rf(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : 32'h1000 + {27'h0, a};
  endfunction

  assign r1d = rf(r1a);
  assign r2d = rf(r2a);

  id_pipe #(.XLEN(32), .NUM_FWD(2)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .inst_i          (inst),
    .inst_addr_i     (inst_addr),
    .reg1_raddr_o    (r1a),
    .reg2_raddr_o    (r2a),
    .reg1_rdata_i    (r1d),
    .reg2_rdata_i    (r2d),
    .fwd_we_i        (fwd_we),
    .fwd_waddr_i     (fwd_waddr),
    .fwd_wdata_i     (fwd_wdata),
    .lclr_valid_i    (lclr_valid),
    .lclr_addr_i     (lclr_addr),
    .flush_i         (flush),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .out_inst_o      (out_inst),
    .out_inst_addr_o (out_addr),
    .out_op1_o       (out_op1),
    .out_op2_o       (out_op2),
    .out_reg_we_o    (out_we),
    .out_reg_waddr_o (out_waddr),
    .out_long_o      (out_long),
    .stall_o         (stall)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        we;
    logic [4:0]  waddr;
    logic        long_op;
  } exp_t;

  exp_t sb_q[$];
  exp_t exp_in;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic exp_t mk(input logic [31:0] i, input logic [31:0] a, input logic [31:0] o1,
                              input logic [31:0] o2, input logic w, input logic [4:0] wa,
                              input logic lg);
    exp_t e;
    e.inst = i; e.addr = a; e.op1 = o1; e.op2 = o2; e.we = w; e.waddr = wa; e.long_op = lg;
    return e;
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] a, input exp_t e);
    in_valid  = 1'b1;
    inst      = i;
    inst_addr = a;
    exp_in    = e;
  endtask

  // Score the handshakes of the current cycle, then advance to the next negedge.
  task automatic cyc();
    exp_t e;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("spurious_out", {63'h0, out_valid}, 64'h0);
      end else begin
        e = sb_q.pop_front();
        chk("out_inst", {32'h0, out_inst}, {32'h0, e.inst});
        chk("out_addr", {32'h0, out_addr}, {32'h0, e.addr});
        chk("out_op1", {32'h0, out_op1}, {32'h0, e.op1});
        chk("out_op2", {32'h0, out_op2}, {32'h0, e.op2});
        chk("out_we", {63'h0, out_we}, {63'h0, e.we});
        chk("out_waddr", {59'h0, out_waddr}, {59'h0, e.waddr});
        chk("out_long", {63'h0, out_long}, {63'h0, e.long_op});
      end
    end
    if (in_valid === 1'b1 && in_ready === 1'b1) sb_q.push_back(exp_in);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish within 200000");
    $fatal(1, "timeout");
  end

  logic [31:0] i_lw5, i_add, i_div, i_lw7, i_add10, i_addi11;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; lclr_valid = 1'b0;
    lclr_addr = 5'd0; fwd_we = 2'b00; fwd_waddr = '0; fwd_wdata = '0;
    inst = 32'h0; inst_addr = 32'h0; exp_in = '0;
    repeat (2) @(negedge clk);
    #1 chk("rst_in_ready", {63'h0, in_ready}, 64'h0);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_out_inst", {32'h0, out_inst}, 64'h13);
    chk("rst_out_op1", {32'h0, out_op1}, 64'h0);
    chk("rst_out_waddr", {59'h0, out_waddr}, 64'h0);
    chk("rst_out_long", {63'h0, out_long}, 64'h0);
    chk("rst_pending", {32'h0, dut.u_sb.pending_q}, 64'h0);

    // load-use: lw x5,0(x1); add x6,x5,x2 waits for lclr x5 and takes fwd0 data
    i_lw5 = enc_i(12'h0, 5'd1, 3'b010, 5'd5, 7'b0000011);
    i_add = enc_r(7'h0, 5'd2, 5'd5, 3'b000, 5'd6);
    drive(i_lw5, 32'h100, mk(i_lw5, 32'h100, 32'h1001, 32'h0, 1'b1, 5'd5, 1'b1));
    #1;
    chk("lw_raddr1", {59'h0, r1a}, 64'd1);
    chk("lw_raddr2", {59'h0, r2a}, 64'd0);
    cyc();
    drive(i_add, 32'h104, mk(i_add, 32'h104, 32'hDEAD, 32'h1002, 1'b1, 5'd6, 1'b0));
    #1;
    chk("lu_ready_c2", {63'h0, in_ready}, 64'h0);
    chk("lu_stall_c2", {63'h0, stall}, 64'h1);
    chk("lu_pend5", {63'h0, dut.u_sb.pending_q[5]}, 64'h1);
    cyc();
    #1 chk("lu_stall_c3", {63'h0, stall}, 64'h1);
    cyc();
    lclr_valid = 1'b1; lclr_addr = 5'd5;
    fwd_we = 2'b01; fwd_waddr[4:0] = 5'd5; fwd_wdata[31:0] = 32'hDEAD;
    #1;
    chk("lu_ready_c4", {63'h0, in_ready}, 64'h1);
    chk("lu_stall_c4", {63'h0, stall}, 64'h0);
    cyc();
    in_valid = 1'b0; lclr_valid = 1'b0; fwd_we = 2'b00;
    #1 cyc();
    chk("lu_pend5_clr", {63'h0, dut.u_sb.pending_q[5]}, 64'h0);

    // fwd priority, x0 exclusion, and a back-to-back stream of other formats
    fwd_we = 2'b11; fwd_waddr = {5'd3, 5'd3}; fwd_wdata = {32'h11, 32'h22};
    drive(32'hFFF18213, 32'h108, mk(32'hFFF18213, 32'h108, 32'h22, 32'hFFFFFFFF, 1'b1, 5'd4, 1'b0));
    #1 cyc();
    fwd_waddr = {5'd3, 5'd0}; fwd_wdata = {32'h11, 32'h55};
    drive(enc_r(7'h0, 5'd3, 5'd0, 3'b000, 5'd4), 32'h10C,
          mk(enc_r(7'h0, 5'd3, 5'd0, 3'b000, 5'd4), 32'h10C, 32'h0, 32'h11, 1'b1, 5'd4, 1'b0));
    #1 cyc();
    fwd_we = 2'b00;
    drive(32'h0020A423, 32'h110, mk(32'h0020A423, 32'h110, 32'h1001, 32'h1002, 1'b0, 5'd0, 1'b0));
    #1 cyc();
    drive(32'h123451B7, 32'h114, mk(32'h123451B7, 32'h114, 32'h12345000, 32'h0, 1'b1, 5'd3, 1'b0));
    #1 cyc();
    drive(32'h00001497, 32'h118, mk(32'h00001497, 32'h118, 32'h118, 32'h1000, 1'b1, 5'd9, 1'b0));
    #1 cyc();
    drive(32'hFFFFFFFF, 32'h11C, mk(32'h13, 32'h11C, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0));
    #1 chk("nop_raddr1", {59'h0, r1a}, 64'h0);
    cyc();
    drive(32'h00108013, 32'h120, mk(32'h00108013, 32'h120, 32'h1001, 32'h1, 1'b0, 5'd0, 1'b0));
    #1 cyc();
    in_valid = 1'b0;
    #1 cyc();

    // WAW: div x7 then lw x7 waits until the pending bit has actually cleared
    i_div = enc_r(7'b0000001, 5'd9, 5'd8, 3'b100, 5'd7);
    i_lw7 = enc_i(12'h0, 5'd2, 3'b010, 5'd7, 7'b0000011);
    drive(i_div, 32'h200, mk(i_div, 32'h200, 32'h1008, 32'h1009, 1'b1, 5'd7, 1'b1));
    #1 cyc();
    drive(i_lw7, 32'h204, mk(i_lw7, 32'h204, 32'h1002, 32'h0, 1'b1, 5'd7, 1'b1));
    #1;
    chk("waw_ready", {63'h0, in_ready}, 64'h0);
    chk("waw_stall", {63'h0, stall}, 64'h1);
    cyc();
    lclr_valid = 1'b1; lclr_addr = 5'd7;
    #1 chk("waw_ready_clr", {63'h0, in_ready}, 64'h0);
    cyc();
    lclr_valid = 1'b0;
    #1 chk("waw_ready_after", {63'h0, in_ready}, 64'h1);
    cyc();
    in_valid = 1'b0;
    #1 cyc();
    chk("waw_pend7", {63'h0, dut.u_sb.pending_q[7]}, 64'h1);
    lclr_valid = 1'b1; lclr_addr = 5'd7;
    #1 cyc();
    lclr_valid = 1'b0;
    #1 chk("waw_pend7_clr", {63'h0, dut.u_sb.pending_q[7]}, 64'h0);

    // backpressure: held entry stays stable and nothing is lost or duplicated
    out_ready = 1'b0;
    i_add10  = enc_r(7'h0, 5'd2, 5'd1, 3'b000, 5'd10);
    i_addi11 = enc_i(12'd5, 5'd1, 3'b000, 5'd11, 7'b0010011);
    drive(i_add10, 32'h300, mk(i_add10, 32'h300, 32'h1001, 32'h1002, 1'b1, 5'd10, 1'b0));
    #1 chk("bp_ready_first", {63'h0, in_ready}, 64'h1);
    cyc();
    drive(i_addi11, 32'h304, mk(i_addi11, 32'h304, 32'h1001, 32'h5, 1'b1, 5'd11, 1'b0));
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready_hold", {63'h0, in_ready}, 64'h0);
      chk("bp_inst_hold", {32'h0, out_inst}, {32'h0, i_add10});
      chk("bp_op2_hold", {32'h0, out_op2}, 64'h1002);
      cyc();
    end
    out_ready = 1'b1;
    #1 chk("bp_ready_release", {63'h0, in_ready}, 64'h1);
    cyc();
    in_valid = 1'b0;
    #1 cyc();

    // flush kills a held lw x5 and releases its pending bit
    out_ready = 1'b0;
    drive(i_lw5, 32'h400, mk(i_lw5, 32'h400, 32'h1001, 32'h0, 1'b1, 5'd5, 1'b1));
    #1 cyc();
    drive(enc_r(7'h0, 5'd0, 5'd5, 3'b000, 5'd6), 32'h404,
          mk(enc_r(7'h0, 5'd0, 5'd5, 3'b000, 5'd6), 32'h404, 32'h1005, 32'h0, 1'b1, 5'd6, 1'b0));
    flush = 1'b1;
    #1;
    chk("fl_ready", {63'h0, in_ready}, 64'h0);
    chk("fl_pend5", {63'h0, dut.u_sb.pending_q[5]}, 64'h1);
    cyc();
    void'(sb_q.pop_back());
    flush = 1'b0; out_ready = 1'b1;
    #1;
    chk("fl_out_valid", {63'h0, out_valid}, 64'h0);
    chk("fl_pend5_clr", {63'h0, dut.u_sb.pending_q[5]}, 64'h0);
    chk("fl_ready_after", {63'h0, in_ready}, 64'h1);
    chk("fl_stall_after", {63'h0, stall}, 64'h0);
    cyc();
    in_valid = 1'b0;
    #1 cyc();

    // reset while a consumer is stalled behind a held lw x12
    out_ready = 1'b0;
    drive(enc_i(12'h0, 5'd1, 3'b010, 5'd12, 7'b0000011), 32'h500,
          mk(enc_i(12'h0, 5'd1, 3'b010, 5'd12, 7'b0000011), 32'h500, 32'h1001, 32'h0, 1'b1,
             5'd12, 1'b1));
    #1 cyc();
    drive(enc_r(7'h0, 5'd1, 5'd12, 3'b000, 5'd13), 32'h504,
          mk(enc_r(7'h0, 5'd1, 5'd12, 3'b000, 5'd13), 32'h504, 32'h100C, 32'h1001, 1'b1,
             5'd13, 1'b0));
    #1 chk("rs_stall", {63'h0, stall}, 64'h1);
    cyc();
    rst = 1'b1;
    #1 chk("rs_ready_in_rst", {63'h0, in_ready}, 64'h0);
    cyc();
    void'(sb_q.pop_back());
    rst = 1'b0; out_ready = 1'b1;
    #1;
    chk("rs_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rs_out_inst", {32'h0, out_inst}, 64'h13);
    chk("rs_out_long", {63'h0, out_long}, 64'h0);
    chk("rs_pending", {32'h0, dut.u_sb.pending_q}, 64'h0);
    chk("rs_ready_after", {63'h0, in_ready}, 64'h1);
    cyc();
    in_valid = 1'b0;
    #1 cyc();

    chk("queue_empty", 64'(sb_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
